// File: rtl/lcd_pkg.sv
// Shared HD44780 bus definitions: read ops, reader states, default timing.
package lcd_pkg;

  typedef enum logic [1:0] {
    RD_STATUS = 2'd0,
    RD_DATA   = 2'd1,
    RD_WAIT   = 2'd2
  } lcd_rd_op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EN_HIGH,
    S_EN_LOW,
    S_RESP
  } lcd_rd_state_t;

  localparam int unsigned LCD_T_AS      = 2;
  localparam int unsigned LCD_T_EH      = 25;
  localparam int unsigned LCD_T_EL      = 25;
  localparam int unsigned LCD_MAX_POLLS = 1000;
  localparam int unsigned LCD_BF_BIT    = 7;
  localparam int unsigned LCD_TMR_W     = 16;

  // Phase timers count down to zero, so a phase of N cycles loads N-1.
  function automatic logic [LCD_TMR_W-1:0] lcd_phase_len(input int unsigned cycles);
    return LCD_TMR_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/lcd_bus_timer.sv
// Loadable down-counter; done_o is high on the last cycle of a phase.
module lcd_bus_timer
  import lcd_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load_i,
  input  logic [LCD_TMR_W-1:0] len_i,
  output logic                 done_o
);

  logic [LCD_TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = len_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_reader.sv
// HD44780 read-side engine: status/data reads and busy-flag polling.
// Optional poll timeout is enabled by defining LCD_READER_TIMEOUT_EN.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int unsigned T_AS      = LCD_T_AS,
  parameter int unsigned T_EH      = LCD_T_EH,
  parameter int unsigned T_EL      = LCD_T_EL,
  parameter int unsigned MAX_POLLS = LCD_MAX_POLLS
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  output logic       req_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_busy,
  output logic       rsp_timeout,
  input  logic [7:0] LCD_DATA_IN,
  output logic       LCD_EN,
  output logic       LCD_RW,
  output logic       LCD_RS,
  output logic       bus_claim
);

  lcd_rd_state_t        state_q;
  lcd_rd_op_t           op_q;
  logic [7:0]           data_q;
  logic                 req_ready_q, rsp_valid_q, rsp_busy_q;
  logic [7:0]           rsp_data_q;
  logic                 en_q, rw_q, rs_q, claim_q;
  logic                 tmr_load, tmr_done;
  logic [LCD_TMR_W-1:0] tmr_len;
  logic                 timeout_hit, poll_again;

`ifdef LCD_READER_TIMEOUT_EN
  localparam int unsigned POLL_W = $clog2(MAX_POLLS + 1);
  logic [POLL_W-1:0] polls_q;
  logic              rsp_to_q;

  assign timeout_hit = (op_q == RD_WAIT) && data_q[LCD_BF_BIT] &&
                       (polls_q == POLL_W'(MAX_POLLS - 1));
  assign rsp_timeout = rsp_to_q;
`else
  assign timeout_hit = 1'b0;
  // MAX_POLLS only has an effect in the timeout build.
  assign rsp_timeout = 1'b0 & (MAX_POLLS == 0);
`endif

  assign poll_again = (op_q == RD_WAIT) && data_q[LCD_BF_BIT] && !timeout_hit;

  always_comb begin
    tmr_load = 1'b0;
    tmr_len  = '0;
    unique case (state_q)
      S_IDLE:    if (req_valid) begin tmr_load = 1'b1; tmr_len = lcd_phase_len(T_AS); end
      S_SETUP:   if (tmr_done)  begin tmr_load = 1'b1; tmr_len = lcd_phase_len(T_EH); end
      S_EN_HIGH: if (tmr_done)  begin tmr_load = 1'b1; tmr_len = lcd_phase_len(T_EL); end
      S_EN_LOW:  if (tmr_done && poll_again) begin
        tmr_load = 1'b1;
        tmr_len  = lcd_phase_len(T_AS);
      end
      default: ;
    endcase
  end

  lcd_bus_timer u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load_i (tmr_load),
    .len_i  (tmr_len),
    .done_o (tmr_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= RD_STATUS;
      data_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_busy_q  <= 1'b0;
      en_q        <= 1'b0;
      rw_q        <= 1'b0;
      rs_q        <= 1'b0;
      claim_q     <= 1'b0;
`ifdef LCD_READER_TIMEOUT_EN
      polls_q     <= '0;
      rsp_to_q    <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            state_q     <= S_SETUP;
            op_q        <= lcd_rd_op_t'(req_op);
            req_ready_q <= 1'b0;
            claim_q     <= 1'b1;
            rw_q        <= 1'b1;
            rs_q        <= (req_op == RD_DATA);
`ifdef LCD_READER_TIMEOUT_EN
            polls_q     <= '0;
`endif
          end
        end
        S_SETUP: begin
          if (tmr_done) begin
            state_q <= S_EN_HIGH;
            en_q    <= 1'b1;
          end
        end
        S_EN_HIGH: begin
          if (tmr_done) begin
            state_q <= S_EN_LOW;
            en_q    <= 1'b0;
            data_q  <= LCD_DATA_IN;
          end
        end
        S_EN_LOW: begin
          if (tmr_done) begin
            if (poll_again) begin
              state_q <= S_SETUP;
`ifdef LCD_READER_TIMEOUT_EN
              polls_q <= polls_q + POLL_W'(1);
`endif
            end else begin
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= data_q;
              rsp_busy_q  <= (op_q == RD_DATA) ? 1'b0 : data_q[LCD_BF_BIT];
`ifdef LCD_READER_TIMEOUT_EN
              rsp_to_q    <= timeout_hit;
`endif
            end
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          claim_q     <= 1'b0;
          rw_q        <= 1'b0;
          rs_q        <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_busy  = rsp_busy_q;
  assign LCD_EN    = en_q;
  assign LCD_RW    = rw_q;
  assign LCD_RS    = rs_q;
  assign bus_claim = claim_q;

endmodule
